// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the processor's instruction memory.
package imem_boot_loader_pkg;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = 8;
    localparam int WORD_BYTES  = 4;
    localparam int BYTE_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CLEAR,
        RUN
    } loader_state_t;

    function automatic logic is_busy(input loader_state_t s);
        return (s == RECV) || (s == WRITE) || (s == CLEAR);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
interface imem_boot_loader_if
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = WORD_BYTES * BYTE_W
);

    logic [BYTE_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_byte_assembler.sv
// Packs an MSB-first byte stream into instruction words; word_valid marks the byte that completes a word.
module imem_byte_assembler
    import imem_boot_loader_pkg::*;
#(
    parameter int DATA_W = WORD_BYTES * BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    localparam int                IDX_W    = $clog2(WORD_BYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [IDX_W-1:0] idx;

    assign word_valid = shift_en && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= '0;
            idx  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (shift_en) begin
            word <= {word[DATA_W-BYTE_W-1:0], byte_in};
            idx  <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the CPU in reset, loads a byte-streamed program into
// instruction memory from address 0, zero-fills the rest, then releases the CPU.
//
//   state | meaning
//   IDLE  | waiting for start, CPU held in reset
//   RECV  | accepting program bytes
//   WRITE | writing one assembled word, no byte accepted
//   CLEAR | writing zero words up to the last address
//   RUN   | CPU released; start reloads
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = WORD_BYTES * BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    imem_boot_loader_if.slave bus,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W + 1)'(DEPTH - 1);

    loader_state_t     state;
    loader_state_t     state_next;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W:0]   ptr_inc;
    logic [ADDR_W:0]   count;
    logic              start_ok;
    logic              shift_en;
    logic [DATA_W-1:0] word;
    logic              word_valid;

    assign start_ok = start && ((state == IDLE) || (state == RUN));
    assign shift_en = bus.byte_valid && (state == RECV);
    assign ptr_inc  = ptr + 1'b1;

    imem_byte_assembler #(
        .DATA_W (DATA_W)
    ) u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .shift_en   (shift_en),
        .byte_in    (bus.byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        bus.byte_ready = 1'b0;
        bus.imem_we    = 1'b0;
        bus.imem_addr  = ptr[ADDR_W-1:0];
        bus.imem_wdata = '0;
        unique case (state)
            RECV: begin
                bus.byte_ready = 1'b1;
                if (word_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                bus.imem_we    = 1'b1;
                bus.imem_wdata = word;
                if (ptr_inc < count) begin
                    state_next = RECV;
                end else if (count < DEPTH_L) begin
                    state_next = CLEAR;
                end else begin
                    state_next = RUN;
                end
            end
            CLEAR: begin
                bus.imem_we = 1'b1;
                if (ptr == LAST_L) begin
                    state_next = RUN;
                end
            end
            default: ;
        endcase
        // A fresh start overrides whatever RUN/IDLE would otherwise do.
        if (start_ok) begin
            if (word_count > DEPTH_L) begin
                state_next = IDLE;
            end else if (word_count == '0) begin
                state_next = CLEAR;
            end else begin
                state_next = RECV;
            end
        end
    end

    // The pointer is one bit wider than the address so a full-depth load ends at DEPTH instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= (state_next == RUN) && (state != RUN);
            if (start_ok) begin
                if (word_count > DEPTH_L) begin
                    err <= 1'b1;
                end else begin
                    err   <= 1'b0;
                    ptr   <= '0;
                    count <= word_count;
                end
            end else if ((state == WRITE) || ((state == CLEAR) && (ptr != LAST_L))) begin
                ptr <= ptr_inc;
            end
        end
    end

    assign cpu_reset = (state != RUN);
    assign busy      = is_busy(state);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a memory-image reference model.
module tb_imem_boot_loader;

    localparam int DEPTH = 256;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] word_count;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       err;

    imem_boot_loader_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    imem_boot_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (8),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int          errors   = 0;
    int          checks   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  q_bytes[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.imem_we) begin
                wr_addr_q.push_back(int'(bus.imem_addr));
                wr_data_q.push_back(bus.imem_wdata);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int i);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < 4; k++) w = (w << 8) | 32'(q_bytes[4*i + k]);
        return w;
    endfunction

    task automatic fill_random(input int n);
        q_bytes.delete();
        for (int i = 0; i < 4 * n; i++) q_bytes.push_back(8'($urandom));
    endtask

    // Expected image: program words at 0..n-1, zeros above, every address written once in order.
    task automatic verify_mem(input int n);
        int lim;
        chk("wr_count", wr_addr_q.size(), DEPTH);
        lim = (wr_addr_q.size() < DEPTH) ? wr_addr_q.size() : DEPTH;
        for (int i = 0; i < lim; i++) begin
            chk($sformatf("wr_addr[%0d]", i), wr_addr_q[i], i);
            chk($sformatf("wr_data[%0d]", i), wr_data_q[i], (i < n) ? model_word(i) : 32'h0);
        end
    endtask

    // gap_mode: 0 = byte every cycle, 1 = three idle cycles between bytes, 2 = random 0..2 idle cycles.
    task automatic send_bytes(input int first, input int cnt, input int gap_mode);
        int guard;
        int gap;
        for (int i = first; i < first + cnt; i++) begin
            bus.byte_data  = q_bytes[i];
            bus.byte_valid = 1'b1;
            guard = 0;
            @(negedge clk);
            while (!bus.byte_ready && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 1000) begin
                chk("ready_timeout", 0, 1);
                bus.byte_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            bus.byte_valid = 1'b0;
            gap = (gap_mode == 1) ? 3 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (i == first + cnt - 1) gap = 0;
            repeat (gap) begin
                @(negedge clk);
                chk("busy_stall", busy, 1);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk);
        #1;
        start      = 1'b1;
        word_count = 9'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_load(input int n, input int gap_mode, input bit check_lat, input bit poke);
        int start_cyc;
        int d0;
        int guard;
        wr_addr_q.delete();
        wr_data_q.delete();
        d0 = done_cnt;
        pulse_start(n);
        start_cyc = cyc;
        chk("cpu_reset_load", cpu_reset, 1);
        chk("busy_load", busy, 1);
        fork
            send_bytes(0, 4 * n, gap_mode);
            if (poke) begin
                repeat (12) @(posedge clk);
                #1;
                start      = 1'b1;
                word_count = 9'd5;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        guard = 0;
        while (done_cnt == d0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        chk("done_seen", done_cnt != d0, 1);
        // Edge count includes the edge that samples start.
        if (check_lat) chk("edges_to_run", done_cyc - start_cyc + 1, 5 * n + (DEPTH - n) + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("cpu_reset_run", cpu_reset, 0);
        chk("busy_run", busy, 0);
        chk("err_clear", err, 0);
        verify_mem(n);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        start          = 1'b0;
        word_count     = 9'd0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_byte_ready", bus.byte_ready, 0);
        chk("rst_imem_we", bus.imem_we, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_cpu_reset", cpu_reset, 1);
        chk("idle_byte_ready", bus.byte_ready, 0);

        fill_random(18);
        do_load(18, 0, 1'b1, 1'b0);

        q_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        do_load(2, 1, 1'b0, 1'b0);

        q_bytes.delete();
        do_load(0, 0, 1'b1, 1'b0);

        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start(257);
        chk("err_set", err, 1);
        chk("err_cpu_reset", cpu_reset, 1);
        chk("err_busy", busy, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("err_no_writes", wr_addr_q.size(), 0);
        chk("err_sticky", err, 1);

        fill_random(1);
        do_load(1, 0, 1'b1, 1'b0);

        fill_random(4);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start(4);
        send_bytes(0, 6, 0);
        reset = 1'b1;
        #1;
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", bus.byte_ready, 0);
        chk("midrst_we", bus.imem_we, 0);
        chk("midrst_wr_count", wr_addr_q.size(), 1);
        if (wr_data_q.size() > 0) chk("midrst_word0", wr_data_q[0], model_word(0));
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_more_wr", wr_addr_q.size(), 1);
        reset = 1'b0;

        fill_random(5);
        do_load(5, 2, 1'b0, 1'b0);

        fill_random(7);
        do_load(7, 2, 1'b0, 1'b0);

        fill_random(256);
        do_load(256, 0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
